// File: rtl/useq_pkg.sv
// rtl/useq_pkg.sv - shared types and constants for the microsequencer controller
//
// Purpose: sequencing-field encodings, controller state encodings, default
//          widths and datapath flag bit positions.
// Ports:   none (package).

package useq_pkg;

    localparam int          UPC_W_DEF       = 5;
    localparam int          OP_W_DEF        = 4;
    localparam int          STACK_DEPTH_DEF = 4;
    localparam logic [4:0]  DISP_BASE_DEF   = 5'h10;

    // Bit positions inside the {V,C,N,Z} flags vector.
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [2:0] {
        SEQ_NEXT     = 3'd0,
        SEQ_JUMP     = 3'd1,
        SEQ_BRANCH   = 3'd2,
        SEQ_DISPATCH = 3'd3,
        SEQ_CALL     = 3'd4,
        SEQ_RET      = 3'd5,
        SEQ_WAIT     = 3'd6,
        SEQ_HALT     = 3'd7
    } seq_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_FAULT  = 2'd3
    } state_e;

endpackage

// File: rtl/useq_if.sv
// rtl/useq_if.sv - microinstruction fields and upcreg hookup for the microsequencer
//
// Purpose: bundles the decoded microinstruction fields, datapath status and the
//          upcreg load/increment path.
// Ports (signals):
//   seq_op, br_addr, cond_sel, flags, opcode, mem_ready, upc : into the controller
//   load_incr, upc_next                                        : out of the controller
// Modports: master = ROM/datapath/upcreg side, slave = controller side.

interface useq_if
    import useq_pkg::*;
#(
    parameter int UPC_W = UPC_W_DEF,
    parameter int OP_W  = OP_W_DEF
);
    logic [2:0]       seq_op;
    logic [UPC_W-1:0] br_addr;
    logic [1:0]       cond_sel;
    logic [3:0]       flags;
    logic [OP_W-1:0]  opcode;
    logic             mem_ready;
    logic [UPC_W-1:0] upc;
    logic             load_incr;
    logic [UPC_W-1:0] upc_next;

    modport master (
        output seq_op, br_addr, cond_sel, flags, opcode, mem_ready, upc,
        input  load_incr, upc_next
    );

    modport slave (
        input  seq_op, br_addr, cond_sel, flags, opcode, mem_ready, upc,
        output load_incr, upc_next
    );
endinterface

// File: rtl/useq_stack.sv
// rtl/useq_stack.sv - micro-return LIFO
//
// Purpose: small return-address stack; contents are not reset, only the pointer.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset (pointer only)
//   push, din       : write din on top (ignored when full)
//   pop, dout       : dout always shows the top entry; pop removes it (ignored when empty)
//   full, empty     : occupancy flags

module useq_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SP_W = AW + 1;

    logic [SP_W-1:0]  sp;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    assign wr_idx = sp[AW-1:0];
    assign rd_idx = sp[AW-1:0] - 1'b1;
    assign full   = (sp == SP_W'(DEPTH));
    assign empty  = (sp == '0);
    assign dout   = mem[rd_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + 1'b1;
        end else if (pop && !empty) begin
            sp <= sp - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= din;
        end
    end
endmodule

// File: rtl/useq_ctrl.sv
// rtl/useq_ctrl.sv - microsequencer controller driving the micro-PC register
//
// Purpose: decodes the sequencing field each cycle and tells upcreg whether to
//          increment or load upc_next; owns run/halt/fault state.
// Config:  USEQ_STACK_EN enables CALL/RET with the micro-return stack; without
//          it CALL/RET behave as NEXT and fault is tied low.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   start      : begin execution at upc 0 (IDLE/HALTED only)
//   bus        : useq_if slave (microinstruction fields in, load_incr/upc_next out)
//   running    : state is RUN
//   fault      : sticky stack over/underflow, cleared only by reset

module useq_ctrl
    import useq_pkg::*;
#(
    parameter int               UPC_W     = UPC_W_DEF,
    parameter int               OP_W      = OP_W_DEF,
    parameter logic [UPC_W-1:0] DISP_BASE = UPC_W'(DISP_BASE_DEF)
`ifdef USEQ_STACK_EN
    , parameter int             STACK_DEPTH = STACK_DEPTH_DEF
`endif
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  start,
    useq_if.slave bus,
    output logic  running,
    output logic  fault
);
    state_e           state;
    state_e           state_nx;
    logic [UPC_W-1:0] disp_target;

    assign disp_target = DISP_BASE | UPC_W'(bus.opcode);

`ifdef USEQ_STACK_EN
    logic             push;
    logic             pop;
    logic [UPC_W-1:0] ret_addr;
    logic [UPC_W-1:0] stk_dout;
    logic             stk_full;
    logic             stk_empty;

    assign ret_addr = bus.upc + 1'b1;

    useq_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (UPC_W)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (ret_addr),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty)
    );

    assign fault = (state == ST_FAULT);
`else
    assign fault = 1'b0;
`endif

    assign running = (state == ST_RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Default action is "hold": load the current upc back into upcreg.
    always_comb begin
        state_nx      = state;
        bus.load_incr = 1'b1;
        bus.upc_next  = bus.upc;
`ifdef USEQ_STACK_EN
        push          = 1'b0;
        pop           = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                bus.upc_next = '0;
                if (start) begin
                    state_nx = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (start) begin
                    bus.upc_next = '0;
                    state_nx     = ST_RUN;
                end
            end
            ST_RUN: begin
                case (seq_op_e'(bus.seq_op))
                    SEQ_JUMP: bus.upc_next = bus.br_addr;
                    SEQ_BRANCH: begin
                        if (bus.flags[bus.cond_sel]) begin
                            bus.upc_next = bus.br_addr;
                        end else begin
                            bus.load_incr = 1'b0;
                        end
                    end
                    SEQ_DISPATCH: bus.upc_next = disp_target;
`ifdef USEQ_STACK_EN
                    SEQ_CALL: begin
                        if (stk_full) begin
                            state_nx = ST_FAULT;
                        end else begin
                            push         = 1'b1;
                            bus.upc_next = bus.br_addr;
                        end
                    end
                    SEQ_RET: begin
                        if (stk_empty) begin
                            state_nx = ST_FAULT;
                        end else begin
                            pop          = 1'b1;
                            bus.upc_next = stk_dout;
                        end
                    end
`endif
                    // mem_ready releases the wait by incrementing in the same cycle.
                    SEQ_WAIT: bus.load_incr = !bus.mem_ready;
                    SEQ_HALT: state_nx = ST_HALTED;
                    default:  bus.load_incr = 1'b0;
                endcase
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_useq_ctrl.sv
// tb/tb_useq_ctrl.sv - directed self-checking bench for useq_ctrl

module tb_useq_ctrl;
    import useq_pkg::*;

`ifdef USEQ_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       start;
    logic       running;
    logic       fault;
    logic [4:0] upc_q;
    int         checks;
    int         failures;

    useq_if #(.UPC_W(5), .OP_W(4)) bus ();

    useq_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .bus     (bus),
        .running (running),
        .fault   (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // upcreg: load upc_next or increment (wrapping), async reset to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upc_q <= '0;
        end else if (bus.load_incr) begin
            upc_q <= bus.upc_next;
        end else begin
            upc_q <= upc_q + 5'd1;
        end
    end
    assign bus.upc = upc_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input seq_op_e op, input logic [4:0] addr,
                        input logic [4:0] exp_upc, input string tag);
        bus.seq_op  = op;
        bus.br_addr = addr;
        tick();
        check(tag, upc_q, exp_upc);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        check({tag, "_upc"}, upc_q, 5'h00);
        check({tag, "_running"}, running, 1'b0);
        check({tag, "_fault"}, fault, 1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        start         = 1'b0;
        bus.seq_op    = SEQ_NEXT;
        bus.br_addr   = '0;
        bus.cond_sel  = '0;
        bus.flags     = '0;
        bus.opcode    = '0;
        bus.mem_ready = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_load_incr", bus.load_incr, 1'b1);
        check("rst_upc_next", bus.upc_next, 5'h00);
        check("rst_running", running, 1'b0);
        check("rst_fault", fault, 1'b0);
        check("rst_upc", upc_q, 5'h00);
        reset = 1'b0;

        // start, then three NEXTs
        start = 1'b1;
        step(SEQ_NEXT, 5'h00, 5'h00, "start_upc");
        check("start_running", running, 1'b1);
        start = 1'b0;
        step(SEQ_NEXT, 5'h00, 5'h01, "next1");
        step(SEQ_NEXT, 5'h00, 5'h02, "next2");
        step(SEQ_NEXT, 5'h00, 5'h03, "next3");

        // conditional branches
        bus.cond_sel = 2'd0;
        bus.flags    = 4'b0001 << FLAG_Z;
        step(SEQ_BRANCH, 5'h0A, 5'h0A, "br_z_set");
        bus.flags = 4'b0000;
        step(SEQ_BRANCH, 5'h0A, 5'h0B, "br_z_clear");
        bus.cond_sel = 2'd3;
        bus.flags    = 4'b0111;
        step(SEQ_BRANCH, 5'h0A, 5'h0C, "br_v_clear");
        bus.flags = 4'b0001 << FLAG_V;
        step(SEQ_BRANCH, 5'h05, 5'h05, "br_v_set");

        // dispatch, jump, wrap
        bus.opcode = 4'h3;
        step(SEQ_DISPATCH, 5'h00, 5'h13, "disp_3");
        bus.opcode = 4'hF;
        step(SEQ_DISPATCH, 5'h00, 5'h1F, "disp_f");
        step(SEQ_JUMP, 5'h1F, 5'h1F, "jump_1f");
        step(SEQ_NEXT, 5'h00, 5'h00, "wrap");

        // nested call/return, then return on empty stack
        step(SEQ_NEXT, 5'h00, 5'h01, "pre_call1");
        step(SEQ_NEXT, 5'h00, 5'h02, "pre_call2");
        step(SEQ_CALL, 5'h08, STK ? 5'h08 : 5'h03, "call1");
        step(SEQ_CALL, 5'h0C, STK ? 5'h0C : 5'h04, "call2");
        step(SEQ_RET, 5'h00, STK ? 5'h09 : 5'h05, "ret1");
        step(SEQ_RET, 5'h00, STK ? 5'h03 : 5'h06, "ret2");
        check("ret2_fault", fault, 1'b0);
        step(SEQ_RET, 5'h00, STK ? 5'h03 : 5'h07, "ret_empty");
        check("ret_empty_fault", fault, STK);
        check("ret_empty_running", running, !STK);
        start = 1'b1;
        step(SEQ_NEXT, 5'h00, STK ? 5'h03 : 5'h08, "fault_start_ign");
        check("fault_sticky", fault, STK);
        start = 1'b0;
        do_reset("rst1");

        // stack overflow on the fifth nested call
        start = 1'b1;
        step(SEQ_NEXT, 5'h00, 5'h00, "ov_start");
        start = 1'b0;
        step(SEQ_CALL, 5'h04, STK ? 5'h04 : 5'h01, "ov_call1");
        step(SEQ_CALL, 5'h08, STK ? 5'h08 : 5'h02, "ov_call2");
        step(SEQ_CALL, 5'h0C, STK ? 5'h0C : 5'h03, "ov_call3");
        step(SEQ_CALL, 5'h10, STK ? 5'h10 : 5'h04, "ov_call4");
        check("ov_full_nofault", fault, 1'b0);
        step(SEQ_CALL, 5'h14, STK ? 5'h10 : 5'h05, "ov_call5");
        check("ov_fault", fault, STK);
        start = 1'b1;
        step(SEQ_NEXT, 5'h00, STK ? 5'h10 : 5'h06, "ov_start_ign");
        check("ov_running", running, !STK);
        start = 1'b0;
        do_reset("rst2");

        // reset with a non-empty stack empties it
        start = 1'b1;
        step(SEQ_NEXT, 5'h00, 5'h00, "sp_start");
        start = 1'b0;
        step(SEQ_CALL, 5'h08, STK ? 5'h08 : 5'h01, "sp_call");
        do_reset("rst3");
        start = 1'b1;
        step(SEQ_NEXT, 5'h00, 5'h00, "sp_restart");
        start = 1'b0;
        step(SEQ_RET, 5'h00, STK ? 5'h00 : 5'h01, "sp_ret");
        check("sp_ret_fault", fault, STK);
        do_reset("rst4");

        // wait / halt / restart
        start = 1'b1;
        step(SEQ_NEXT, 5'h00, 5'h00, "w_start");
        start = 1'b0;
        step(SEQ_NEXT, 5'h00, 5'h01, "w_next");
        bus.mem_ready = 1'b0;
        step(SEQ_WAIT, 5'h00, 5'h01, "wait1");
        step(SEQ_WAIT, 5'h00, 5'h01, "wait2");
        step(SEQ_WAIT, 5'h00, 5'h01, "wait3");
        bus.mem_ready = 1'b1;
        step(SEQ_WAIT, 5'h00, 5'h02, "wait_release");
        step(SEQ_HALT, 5'h00, 5'h02, "halt");
        check("halt_running", running, 1'b0);
        step(SEQ_NEXT, 5'h00, 5'h02, "halted_hold");
        check("halted_load_incr", bus.load_incr, 1'b1);
        check("halted_upc_next", bus.upc_next, 5'h02);
        start = 1'b1;
        step(SEQ_NEXT, 5'h00, 5'h00, "restart");
        check("restart_running", running, 1'b1);
        start = 1'b0;
        step(SEQ_NEXT, 5'h00, 5'h01, "restart_next");

        // reset in the middle of a wait
        bus.mem_ready = 1'b0;
        step(SEQ_WAIT, 5'h00, 5'h01, "wait_pre_rst");
        do_reset("rst5");
        step(SEQ_NEXT, 5'h00, 5'h00, "idle_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
